matmul_engine: RTL and testbench

//  Parametrised NxN matrix-multiply core, C = A x B, unsigned operands. Successor to the fixed-size p2

---
 rtl/matmul_pkg.sv | 14 +
 rtl/matmul_if.sv | 34 +++
 rtl/mac_unit.sv | 23 ++
 rtl/matmul_engine.sv | 131 +++++++++++++
 tb/tb_matmul_engine.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared FSM state type and derived-width helpers for the matrix-multiply engine
package matmul_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, MAC, STORE, STREAM, DONE} state_t;

    function automatic int aw_of(input int n);
        return $clog2(n * n);
    endfunction

    function automatic int rw_of(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_if.sv
// matmul_if: load, control, result-stream and random-read signals of the matmul engine
interface matmul_if import matmul_pkg::*; #(
    parameter int N  = 4,
    parameter int DW = 8
) ();

    localparam int AW = aw_of(N);
    localparam int RW = rw_of(N, DW);

    logic          ld_en;
    logic          ld_sel;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          start;
    logic          busy;
    logic          done;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_data;
    logic [AW-1:0] res_idx;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_data;

    modport master (
        output ld_en, ld_sel, ld_addr, ld_data, start, res_ready, rd_addr,
        input  busy, done, res_valid, res_data, res_idx, rd_data
    );

    modport slave (
        input  ld_en, ld_sel, ld_addr, ld_data, start, res_ready, rd_addr,
        output busy, done, res_valid, res_data, res_idx, rd_data
    );

endinterface

// File: rtl/mac_unit.sv
// mac_unit: registered multiply-accumulate with synchronous clear
module mac_unit #(
    parameter int DW = 8,
    parameter int RW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [RW-1:0] acc
);

    // accumulate zero-extended products; RW is wide enough that this never wraps
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            acc <= '0;
        else if (en)
            acc <= acc + RW'(a) * RW'(b);
    end

endmodule

// File: rtl/matmul_engine.sv
// matmul_engine: NxN unsigned matrix multiply C = A x B with stream and random-read result ports
module matmul_engine import matmul_pkg::*; #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input logic     CLOCK_50,
    input logic     KEY0,
    matmul_if.slave bus
);

    localparam int AW = aw_of(N);
    localparam int RW = rw_of(N, DW);
    localparam int IW = $clog2(N);
    localparam int KW = $clog2(N + 1);
    localparam logic [KW-1:0] K_END    = KW'(N);
    localparam logic [IW-1:0] LAST_IJ  = IW'(N - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(N * N - 1);
    localparam logic [AW-1:0] N_A      = AW'(N);

    state_t        state, state_nx;
    logic [IW-1:0] i, j;
    logic [KW-1:0] k, kk;
    logic [DW-1:0] a_mem [N*N];
    logic [DW-1:0] b_mem [N*N];
    logic [RW-1:0] c_mem [N*N];
    logic [DW-1:0] a_q, b_q;
    logic [RW-1:0] acc;
    logic [AW-1:0] a_addr, b_addr, c_addr, s_addr;
    logic          idle_like, last_beat, s_load;

    // k runs one ahead of the product being accumulated because operand reads are registered;
    // once it reaches N the read address is parked at 0 to stay in range
    assign kk        = (k == K_END) ? '0 : k;
    assign a_addr    = AW'(i) * N_A + AW'(kk);
    assign b_addr    = AW'(kk) * N_A + AW'(j);
    assign c_addr    = AW'(i) * N_A + AW'(j);
    assign idle_like = state == IDLE || state == DONE;
    assign last_beat = bus.res_valid && bus.res_ready && bus.res_idx == LAST_IDX;
    assign s_load    = state == STREAM && (!bus.res_valid || (bus.res_ready && bus.res_idx != LAST_IDX));
    assign s_addr    = bus.res_valid ? bus.res_idx + 1'b1 : '0;
    assign bus.busy  = !idle_like;
    assign bus.done  = state == DONE;

    mac_unit #(.DW(DW), .RW(RW)) u_mac (
        .clk   (CLOCK_50),
        .rst_n (KEY0),
        .clr   (state == CLEAR),
        .en    (state == MAC),
        .a     (a_q),
        .b     (b_q),
        .acc   (acc)
    );

    // state register
    always_ff @(posedge CLOCK_50) begin
        state <= !KEY0 ? IDLE : state_nx;
    end

    // next-state: CLEAR, N MAC cycles and STORE per element, then stream all of C
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: state_nx = bus.start ? CLEAR : state;
            CLEAR:      state_nx = MAC;
            MAC:        state_nx = (k == K_END) ? STORE : MAC;
            STORE:      state_nx = (i == LAST_IJ && j == LAST_IJ) ? STREAM : CLEAR;
            STREAM:     state_nx = last_beat ? DONE : STREAM;
            default:    state_nx = IDLE;
        endcase
    end

    // i/j walk C row-major; k indexes the inner product
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0 || (bus.start && idle_like)) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (state == CLEAR || state == MAC) begin
            k <= (k == K_END) ? k : k + 1'b1;
        end else if (state == STORE) begin
            k <= '0;
            j <= (j == LAST_IJ) ? '0 : j + 1'b1;
            i <= (j != LAST_IJ) ? i : (i == LAST_IJ) ? '0 : i + 1'b1;
        end
    end

    // operand writes, only while no computation is in flight
    always_ff @(posedge CLOCK_50) begin
        if (bus.ld_en && idle_like && !bus.ld_sel)
            a_mem[bus.ld_addr] <= bus.ld_data;
    end

    // operand writes, only while no computation is in flight
    always_ff @(posedge CLOCK_50) begin
        if (bus.ld_en && idle_like && bus.ld_sel)
            b_mem[bus.ld_addr] <= bus.ld_data;
    end

    // registered operand reads feeding the MAC
    always_ff @(posedge CLOCK_50) begin
        a_q <= a_mem[a_addr];
        b_q <= b_mem[b_addr];
    end

    // commit finished dot product
    always_ff @(posedge CLOCK_50) begin
        if (state == STORE)
            c_mem[c_addr] <= acc;
    end

    // random-access read of C, live in every state
    always_ff @(posedge CLOCK_50) begin
        bus.rd_data <= !KEY0 ? '0 : c_mem[bus.rd_addr];
    end

    // result stream: prime element 0, then advance on each accepted beat, hold under backpressure
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_idx   <= '0;
        end else if (s_load) begin
            bus.res_valid <= 1'b1;
            bus.res_data  <= c_mem[s_addr];
            bus.res_idx   <= s_addr;
        end else if (last_beat) begin
            bus.res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matmul_engine.sv
// tb_matmul_engine: directed checks of the matmul engine at N=4 and N=2
module tb_matmul_engine;

    logic CLOCK_50 = 1'b0;
    logic KEY0;
    int   vecs = 0;
    int   errs = 0;
    int   t = 0;
    int   t0 = 0;
    int   exp4 [16];
    int   a2 [4] = '{1, 2, 3, 4};
    int   b2 [4] = '{5, 6, 7, 8};
    int   c2 [4] = '{19, 22, 43, 50};

    matmul_if #(.N(4), .DW(8)) m4 ();
    matmul_if #(.N(2), .DW(8)) m2 ();

    matmul_engine #(.N(4), .DW(8)) dut4 (.CLOCK_50(CLOCK_50), .KEY0(KEY0), .bus(m4));
    matmul_engine #(.N(2), .DW(8)) dut2 (.CLOCK_50(CLOCK_50), .KEY0(KEY0), .bus(m2));

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        t++;
    endtask

    task automatic load4(input logic sel, input int addr, input int data);
        m4.ld_en   = 1'b1;
        m4.ld_sel  = sel;
        m4.ld_addr = 4'(addr);
        m4.ld_data = 8'(data);
        tick();
        m4.ld_en = 1'b0;
    endtask

    task automatic start4();
        m4.start = 1'b1;
        tick();
        m4.start = 1'b0;
        t0 = t;
    endtask

    task automatic stream4(input int stall);
        m4.res_ready = 1'b1;
        while (!m4.res_valid && t - t0 < 300) tick();
        check("latency4", t - t0, 97);
        for (int b = 0; b < 16; b++) begin
            if (b == stall) begin
                m4.res_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check("stall_valid", m4.res_valid, 1);
                    check("stall_data", m4.res_data, exp4[b]);
                    check("stall_idx", m4.res_idx, b);
                end
                m4.res_ready = 1'b1;
            end
            check("beat_valid", m4.res_valid, 1);
            check("beat_data", m4.res_data, exp4[b]);
            check("beat_idx", m4.res_idx, b);
            tick();
        end
        check("done_time", t - t0, 97 + 16 + (stall >= 0 ? 5 : 0));
        check("done4", m4.done, 1);
        check("busy_end4", m4.busy, 0);
        check("valid_end4", m4.res_valid, 0);
    endtask

    initial begin
        KEY0 = 1'b0;
        {m4.ld_en, m4.ld_sel, m4.ld_addr, m4.ld_data, m4.start, m4.res_ready, m4.rd_addr} = '0;
        {m2.ld_en, m2.ld_sel, m2.ld_addr, m2.ld_data, m2.start, m2.res_ready, m2.rd_addr} = '0;
        tick();
        tick();
        check("rst_busy", m4.busy, 0);
        check("rst_done", m4.done, 0);
        check("rst_valid", m4.res_valid, 0);
        check("rst_data", m4.res_data, 0);
        check("rst_idx", m4.res_idx, 0);
        check("rst_rd", m4.rd_data, 0);
        check("rst_busy2", m2.busy, 0);
        check("rst_valid2", m2.res_valid, 0);
        KEY0 = 1'b1;
        tick();

        // identity A, B = 1..16
        for (int a = 0; a < 16; a++) begin
            load4(1'b0, a, (a / 4 == a % 4) ? 1 : 0);
            load4(1'b1, a, a + 1);
            exp4[a] = a + 1;
        end
        start4();
        check("busy_after_start", m4.busy, 1);
        check("done_after_start", m4.done, 0);
        stream4(-1);
        m4.rd_addr = 4'd5;
        tick();
        check("rd_c5_ident", m4.rd_data, 6);

        // restart from DONE with a 5-cycle stall on beat 3
        start4();
        check("done_cleared", m4.done, 0);
        check("busy_restart", m4.busy, 1);
        stream4(3);

        // load and start during MAC are ignored
        start4();
        tick();
        tick();
        m4.ld_en   = 1'b1;
        m4.ld_sel  = 1'b0;
        m4.ld_addr = 4'd0;
        m4.ld_data = 8'd9;
        m4.start   = 1'b1;
        tick();
        m4.ld_en = 1'b0;
        m4.start = 1'b0;
        check("busy_mac_poke", m4.busy, 1);
        stream4(-1);

        // all-255 operands: maximal accumulation
        for (int a = 0; a < 16; a++) begin
            load4(1'b0, a, 255);
            load4(1'b1, a, 255);
            exp4[a] = 260100;
        end
        start4();
        stream4(-1);
        m4.rd_addr = 4'd5;
        tick();
        check("rd_c5_max", m4.rd_data, 260100);

        // reset during MAC, then a clean rerun
        start4();
        tick();
        tick();
        tick();
        check("busy_pre_abort", m4.busy, 1);
        KEY0 = 1'b0;
        tick();
        check("abort_busy", m4.busy, 0);
        check("abort_done", m4.done, 0);
        check("abort_valid", m4.res_valid, 0);
        check("abort_data", m4.res_data, 0);
        KEY0 = 1'b1;
        tick();
        start4();
        stream4(-1);

        // N=2 instance
        for (int a = 0; a < 4; a++) begin
            m2.ld_en = 1'b1; m2.ld_sel = 1'b0; m2.ld_addr = 2'(a); m2.ld_data = 8'(a2[a]);
            tick();
            m2.ld_sel = 1'b1; m2.ld_data = 8'(b2[a]);
            tick();
            m2.ld_en = 1'b0;
        end
        m2.start = 1'b1;
        tick();
        m2.start = 1'b0;
        t0 = t;
        m2.res_ready = 1'b1;
        while (!m2.res_valid && t - t0 < 100) tick();
        check("latency2", t - t0, 17);
        for (int b = 0; b < 4; b++) begin
            check("beat2_valid", m2.res_valid, 1);
            check("beat2_data", m2.res_data, c2[b]);
            check("beat2_idx", m2.res_idx, b);
            tick();
        end
        check("done2", m2.done, 1);
        check("valid_end2", m2.res_valid, 0);
        m2.rd_addr = 2'd3;
        tick();
        check("rd2_c3", m2.rd_data, 50);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
